sram16_port: RTL and testbench

SRAM16_PORT -- requirements
Module: sram16_port

---
 rtl/sram16_port.sv | 151 +++++++++++++++
 tb/tb_sram16_port.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sram16_port.sv
// sram16_port: bridges a single-beat bus request to an asynchronous 16-bit SRAM.
//
// A request (cyc_i & stb_i) sampled in IDLE is latched and held on the SRAM
// pins for WAIT_STATES+1 cycles (ACCESS). The access then completes with a
// one-cycle ack_o (ACK), followed by a one-cycle bus turnaround (TURN).
// Dropping cyc_i during ACCESS aborts the access without an ack.
//
// Ports
//   clk_i, reset_i        clock, asynchronous active-low reset
//   adr_i[63:0]           byte address (bits ADR_BITS-1:0 used)
//   cyc_i, stb_i, we_i    bus cycle, strobe, write enable
//   siz_i                 0 = byte, 1 = halfword
//   dat_i[15:0]           write data
//   ack_o, dat_o[15:0]    transfer complete, read data (held until next read)
//   sram_a_o              halfword address (adr bits ADR_BITS-1:1)
//   sram_d_i, sram_d_o    SRAM data in / out
//   sram_d_oe_o           SRAM data bus drive enable
//   sram_*_n_o            active-low chip/output/write enable, byte lanes
module sram16_port #(
    parameter int ADR_BITS    = 20,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [63:0]         adr_i,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic                siz_i,
    input  logic [15:0]         dat_i,
    output logic                ack_o,
    output logic [15:0]         dat_o,
    output logic [ADR_BITS-2:0] sram_a_o,
    input  logic [15:0]         sram_d_i,
    output logic [15:0]         sram_d_o,
    output logic                sram_d_oe_o,
    output logic                sram_ce_n_o,
    output logic                sram_oe_n_o,
    output logic                sram_we_n_o,
    output logic                sram_lb_n_o,
    output logic                sram_ub_n_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK,
        TURN
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          wait_q, wait_d;
    logic [ADR_BITS-1:0] adr_q, adr_d;
    logic                we_q, we_d;
    logic                siz_q, siz_d;
    logic [15:0]         dat_q, dat_d;
    logic [15:0]         rdat_q, rdat_d;

    // Address bits above the SRAM range are ignored.
    generate
        if (ADR_BITS < 64) begin : g_adr_hi
            logic unused_adr_hi;
            assign unused_adr_hi = ^adr_i[63:ADR_BITS];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            wait_q  <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            siz_q   <= 1'b0;
            dat_q   <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            siz_q   <= siz_d;
            dat_q   <= dat_d;
            rdat_q  <= rdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        adr_d   = adr_q;
        we_d    = we_q;
        siz_d   = siz_q;
        dat_d   = dat_q;
        rdat_d  = rdat_q;
        case (state_q)
            IDLE: begin
                if (cyc_i && stb_i) begin
                    state_d = ACCESS;
                    wait_d  = 4'(WAIT_STATES);
                    adr_d   = adr_i[ADR_BITS-1:0];
                    we_d    = we_i;
                    siz_d   = siz_i;
                    dat_d   = dat_i;
                end
            end
            ACCESS: begin
                // Abort wins over completion, even on the last ACCESS cycle.
                if (!cyc_i) begin
                    state_d = TURN;
                    wait_d  = '0;
                end else if (wait_q == 4'd0) begin
                    state_d = ACK;
                    if (!we_q) begin
                        // Byte reads are right-justified and zero-extended.
                        if (siz_q)
                            rdat_d = sram_d_i;
                        else if (adr_q[0])
                            rdat_d = {8'h00, sram_d_i[15:8]};
                        else
                            rdat_d = {8'h00, sram_d_i[7:0]};
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ACK:     state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from the state flops so reset releases the bus at once.
    logic in_access;
    assign in_access = (state_q == ACCESS);

    always_comb begin
        ack_o       = (state_q == ACK);
        sram_ce_n_o = !in_access;
        sram_oe_n_o = !(in_access && !we_q);
        sram_we_n_o = !(in_access && we_q);
        sram_lb_n_o = !(in_access && (siz_q || !adr_q[0]));
        sram_ub_n_o = !(in_access && (siz_q || adr_q[0]));
        // Write data stays driven through ACK for hold time after we_n rises.
        sram_d_oe_o = we_q && (in_access || state_q == ACK);
    end

    assign sram_a_o = adr_q[ADR_BITS-1:1];
    assign sram_d_o = siz_q ? dat_q : {dat_q[7:0], dat_q[7:0]};
    assign dat_o    = rdat_q;

endmodule

// File: tb/tb_sram16_port.sv
// tb_sram16_port: directed + randomized checks of sram16_port against a
// transaction-level reference (expected memory image, expected pins per cycle).
module tb_sram16_port;
    localparam int ADR_BITS = 20;
    localparam int WS       = 2;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic [63:0]         adr_i;
    logic                cyc_i, stb_i, we_i, siz_i;
    logic [15:0]         dat_i;
    logic                ack_o;
    logic [15:0]         dat_o;
    logic [ADR_BITS-2:0] sram_a_o;
    logic [15:0]         sram_d_i, sram_d_o;
    logic                sram_d_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
    logic                sram_lb_n_o, sram_ub_n_o;

    sram16_port #(.ADR_BITS(ADR_BITS), .WAIT_STATES(WS)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .adr_i(adr_i), .cyc_i(cyc_i),
        .stb_i(stb_i), .we_i(we_i), .siz_i(siz_i), .dat_i(dat_i),
        .ack_o(ack_o), .dat_o(dat_o), .sram_a_o(sram_a_o),
        .sram_d_i(sram_d_i), .sram_d_o(sram_d_o), .sram_d_oe_o(sram_d_oe_o),
        .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
        .sram_we_n_o(sram_we_n_o), .sram_lb_n_o(sram_lb_n_o),
        .sram_ub_n_o(sram_ub_n_o)
    );

    always #5 clk_i = ~clk_i;

    // SRAM model: 32 halfwords indexed by the low address bits.
    logic [15:0] mem [0:31];
    logic        poke;
    logic [4:0]  poke_idx;
    logic [15:0] poke_val;
    assign sram_d_i = mem[sram_a_o[4:0]];

    always @(posedge clk_i) begin
        if (poke)
            mem[poke_idx] <= poke_val;
        else if (!sram_ce_n_o && !sram_we_n_o) begin
            if (!sram_lb_n_o) mem[sram_a_o[4:0]][7:0]  <= sram_d_o[7:0];
            if (!sram_ub_n_o) mem[sram_a_o[4:0]][15:8] <= sram_d_o[15:8];
        end
    end

    int acks_seen = 0;
    always @(posedge clk_i) if (ack_o === 1'b1) acks_seen <= acks_seen + 1;

    // Reference state
    logic [15:0] ref_mem [0:31];
    logic [15:0] exp_dato;
    int          exp_acks;
    int          n_chk, n_fail;

    logic [4:0] strb;
    assign strb = {sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_lb_n_o, sram_ub_n_o};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic poke_mem(input logic [4:0] idx, input logic [15:0] val);
        poke = 1'b1; poke_idx = idx; poke_val = val;
        @(posedge clk_i); #1;
        poke = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_strb"}, 32'(strb), 32'h1F);
        chk({tag, "_doe"},  32'(sram_d_oe_o), 32'h0);
        chk({tag, "_ack"},  32'(ack_o), 32'h0);
        chk({tag, "_dato"}, 32'(dat_o), 32'(exp_dato));
    endtask

    // One transfer: abort_at = ACCESS cycle (1..WS+1) in which cyc_i drops,
    // 0 for none; keep = leave the request asserted after the ack.
    task automatic xfer(input bit w, input bit sz, input logic [19:0] a,
                        input logic [15:0] d, input int abort_at, input bit keep);
        logic [4:0]  idx;
        logic [4:0]  exp_strb;
        logic [15:0] exp_do;
        idx      = a[5:1];
        exp_strb = {1'b0, w, !w, !(sz || !a[0]), !(sz || a[0])};
        exp_do   = sz ? d : {d[7:0], d[7:0]};

        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; siz_i = sz;
        adr_i = {44'h0, a}; dat_i = d;
        @(negedge clk_i);
        check_quiet("idle");

        for (int k = 1; k <= WS + 1; k++) begin
            @(posedge clk_i); #1;
            if (k == 1) stb_i = 1'($urandom_range(0, 1));
            if (k == abort_at) cyc_i = 1'b0;
            @(negedge clk_i);
            chk("acc_strb", 32'(strb), 32'(exp_strb));
            chk("acc_a",    32'(sram_a_o), 32'(a[19:1]));
            chk("acc_doe",  32'(sram_d_oe_o), 32'(w));
            chk("acc_ack",  32'(ack_o), 32'h0);
            chk("acc_dato", 32'(dat_o), 32'(exp_dato));
            if (w) chk("acc_do", 32'(sram_d_o), 32'(exp_do));
            if (k == abort_at) break;
        end

        if (abort_at != 0) begin
            @(posedge clk_i); #1;
            stb_i = 1'b0;
            @(negedge clk_i);
            check_quiet("abort_turn");
            return;
        end

        @(posedge clk_i); #1;
        if (!keep) begin cyc_i = 1'b0; stb_i = 1'b0; end
        else stb_i = 1'b1;
        if (w) begin
            if (sz)        ref_mem[idx]       = d;
            else if (a[0]) ref_mem[idx][15:8] = d[7:0];
            else           ref_mem[idx][7:0]  = d[7:0];
        end else begin
            exp_dato = sz ? ref_mem[idx]
                          : {8'h00, (a[0] ? ref_mem[idx][15:8] : ref_mem[idx][7:0])};
        end
        exp_acks++;
        @(negedge clk_i);
        chk("ack_ack",  32'(ack_o), 32'h1);
        chk("ack_strb", 32'(strb), 32'h1F);
        chk("ack_doe",  32'(sram_d_oe_o), 32'(w));
        chk("ack_dato", 32'(dat_o), 32'(exp_dato));

        @(posedge clk_i); #1;
        @(negedge clk_i);
        check_quiet("turn");
    endtask

    initial begin
        n_chk = 0; n_fail = 0; exp_acks = 0; exp_dato = 16'h0;
        reset_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; siz_i = 1'b0;
        adr_i = 64'h0; dat_i = 16'h0;
        poke = 1'b0; poke_idx = 5'h0; poke_val = 16'h0;
        #2;
        check_quiet("rst");
        chk("rst_a",  32'(sram_a_o), 32'h0);
        chk("rst_do", 32'(sram_d_o), 32'h0);

        for (int i = 0; i < 32; i++) poke_mem(5'(i), 16'($urandom));
        @(posedge clk_i); #1;
        reset_i = 1'b1;

        // Halfword read
        poke_mem(5'h1A, 16'hBEEF);
        xfer(1'b0, 1'b1, 20'h01234, 16'h0, 0, 1'b0);
        chk("hw_rd_dat", 32'(dat_o), 32'hBEEF);
        // Byte read, odd address
        poke_mem(5'h1A, 16'hAA55);
        xfer(1'b0, 1'b0, 20'h01235, 16'h0, 0, 1'b0);
        chk("by_rd_dat", 32'(dat_o), 32'h00AA);
        // Byte write, even address, then read back the whole halfword
        xfer(1'b1, 1'b0, 20'h00010, 16'h0077, 0, 1'b0);
        xfer(1'b0, 1'b1, 20'h00010, 16'h0, 0, 1'b0);
        chk("by_wr_lo", 32'(dat_o[7:0]), 32'h77);
        // Back-to-back: request held through ACK and TURN
        xfer(1'b0, 1'b1, 20'h00022, 16'h0, 0, 1'b1);
        xfer(1'b0, 1'b1, 20'h00024, 16'h0, 0, 1'b0);
        // Abort in the 2nd ACCESS cycle keeps the previous read data
        poke_mem(5'h1A, 16'hBEEF);
        xfer(1'b0, 1'b1, 20'h01234, 16'h0, 0, 1'b0);
        xfer(1'b0, 1'b1, 20'h00400, 16'h0, 2, 1'b0);
        chk("abort_dat", 32'(dat_o), 32'hBEEF);

        // Randomized transfers
        for (int n = 0; n < 40; n++) begin
            bit          w, sz, kp;
            int          ab;
            logic [19:0] a;
            w  = 1'($urandom_range(0, 1));
            sz = 1'($urandom_range(0, 1));
            kp = 1'($urandom_range(0, 1));
            a  = 20'($urandom);
            ab = (!w && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, WS + 1)) : 0;
            xfer(w, sz, a, 16'($urandom), ab, kp);
        end

        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("ack_count", 32'(acks_seen), 32'(exp_acks));

        // Reset in the middle of a write releases the bus immediately
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; siz_i = 1'b1;
        adr_i = 64'h0000_0000_0000_0246; dat_i = 16'h1357;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rw_we",  32'(sram_we_n_o), 32'h0);
        chk("rw_doe", 32'(sram_d_oe_o), 32'h1);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        #1;
        exp_dato = 16'h0;
        check_quiet("rw_rst");
        chk("rw_a",  32'(sram_a_o), 32'h0);
        chk("rw_do", 32'(sram_d_o), 32'h0);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_quiet("rw_post");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
